// File: rtl/sprite_compositor_if.sv
// Signal bundle between the scan/attribute source, the sprite ROMs and the
// compositor. The compositor connects through the slave modport.
interface sprite_compositor_if #(
    parameter int NUM_SPRITES = 2,
    parameter int ADDR_W      = 14
);
    localparam int NUM_PAIRS = NUM_SPRITES * (NUM_SPRITES - 1) / 2;

    logic [9:0]                    col;
    logic [9:0]                    row;
    logic                          valid;
    logic                          frame_tick;
    logic [NUM_SPRITES-1:0]        attr_en;
    logic [10*NUM_SPRITES-1:0]     attr_x;
    logic [10*NUM_SPRITES-1:0]     attr_y;
    logic [7*NUM_SPRITES-1:0]      attr_w;
    logic [7*NUM_SPRITES-1:0]      attr_h;
    logic [NUM_SPRITES-1:0]        attr_flip;
    logic [8*NUM_SPRITES-1:0]      attr_stride;
    logic [11*NUM_SPRITES-1:0]     attr_anim_row;
    logic [11*NUM_SPRITES-1:0]     attr_anim_col;
    logic [ADDR_W*NUM_SPRITES-1:0] spr_addr;
    logic [6*NUM_SPRITES-1:0]      spr_rgb;
    logic [5:0]                    bg_rgb;
    logic [5:0]                    rgb_out;
    logic                          valid_out;
    logic [NUM_PAIRS-1:0]          coll_pairs;
    logic                          any_coll;

    modport master (
        output col, row, valid, frame_tick,
        output attr_en, attr_x, attr_y, attr_w, attr_h, attr_flip,
        output attr_stride, attr_anim_row, attr_anim_col,
        output spr_rgb, bg_rgb,
        input  spr_addr, rgb_out, valid_out, coll_pairs, any_coll
    );

    modport slave (
        input  col, row, valid, frame_tick,
        input  attr_en, attr_x, attr_y, attr_w, attr_h, attr_flip,
        input  attr_stride, attr_anim_row, attr_anim_col,
        input  spr_rgb, bg_rgb,
        output spr_addr, rgb_out, valid_out, coll_pairs, any_coll
    );
endinterface

// File: rtl/sprite_compositor.sv
// N-channel sprite engine: per-channel hit/ROM address generation, ROM-latency
// alignment, priority compositing over background and per-frame collision flags.
module sprite_compositor #(
    parameter int         NUM_SPRITES = 2,
    parameter int         ROM_LATENCY = 1,
    parameter int         ADDR_W      = 14,
    parameter int         SCALE_SHIFT = 1,
    parameter logic [5:0] KEY_RGB     = 6'b110011
) (
    input logic           clk,
    input logic           rst_n,
    sprite_compositor_if.slave bus
);
    localparam int NUM_PAIRS = NUM_SPRITES * (NUM_SPRITES - 1) / 2;
    localparam int DEPTH     = 1 + ROM_LATENCY;

    // Active attribute set, only reloaded on frame_tick so a frame never tears.
    logic [NUM_SPRITES-1:0]    en_reg;
    logic [10*NUM_SPRITES-1:0] x_reg;
    logic [10*NUM_SPRITES-1:0] y_reg;
    logic [7*NUM_SPRITES-1:0]  w_reg;
    logic [7*NUM_SPRITES-1:0]  h_reg;
    logic [NUM_SPRITES-1:0]    flip_reg;
    logic [8*NUM_SPRITES-1:0]  stride_reg;
    logic [11*NUM_SPRITES-1:0] anim_row_reg;
    logic [11*NUM_SPRITES-1:0] anim_col_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            en_reg       <= '0;
            x_reg        <= '0;
            y_reg        <= '0;
            w_reg        <= '0;
            h_reg        <= '0;
            flip_reg     <= '0;
            stride_reg   <= '0;
            anim_row_reg <= '0;
            anim_col_reg <= '0;
        end else if (bus.frame_tick) begin
            en_reg       <= bus.attr_en;
            x_reg        <= bus.attr_x;
            y_reg        <= bus.attr_y;
            w_reg        <= bus.attr_w;
            h_reg        <= bus.attr_h;
            flip_reg     <= bus.attr_flip;
            stride_reg   <= bus.attr_stride;
            anim_row_reg <= bus.attr_anim_row;
            anim_col_reg <= bus.attr_anim_col;
        end
    end

    logic [NUM_SPRITES-1:0] hit_a;
    logic [10:0]            col11;
    logic [10:0]            row11;

    assign col11 = {1'b0, bus.col};
    assign row11 = {1'b0, bus.row};

    genvar gi, gj;
    generate
        for (gi = 0; gi < NUM_SPRITES; gi++) begin : g_chan
            logic [10:0]       x11, y11, sw, sh, dx, dy, cx, cx_f, ry;
            logic [21:0]       addr_full;
            logic [ADDR_W-1:0] addr_next;
            logic [ADDR_W-1:0] addr_reg;

            // 11-bit arithmetic keeps x+sw past the right edge from wrapping.
            assign x11 = {1'b0, x_reg[10*gi +: 10]};
            assign y11 = {1'b0, y_reg[10*gi +: 10]};
            assign sw  = {4'b0, w_reg[7*gi +: 7]} << SCALE_SHIFT;
            assign sh  = {4'b0, h_reg[7*gi +: 7]} << SCALE_SHIFT;
            assign dx  = col11 - x11;
            assign dy  = row11 - y11;

            assign hit_a[gi] = en_reg[gi] && (col11 >= x11) && (col11 < x11 + sw)
                               && (row11 >= y11) && (row11 < y11 + sh);

            assign cx   = dx >> SCALE_SHIFT;
            assign ry   = dy >> SCALE_SHIFT;
            assign cx_f = flip_reg[gi] ? ({4'b0, w_reg[7*gi +: 7]} - 11'd1 - cx) : cx;

            assign addr_full = ({11'b0, ry} + {11'b0, anim_row_reg[11*gi +: 11]})
                               * {14'b0, stride_reg[8*gi +: 8]}
                               + {11'b0, cx_f} + {11'b0, anim_col_reg[11*gi +: 11]};
            assign addr_next = hit_a[gi] ? addr_full[ADDR_W-1:0] : '0;

            always_ff @(posedge clk) begin
                if (!rst_n) addr_reg <= '0;
                else        addr_reg <= addr_next;
            end

            assign bus.spr_addr[ADDR_W*gi +: ADDR_W] = addr_reg;
        end
    endgenerate

    // Hit flags and valid ride alongside the ROM access so they meet spr_rgb.
    logic [NUM_SPRITES-1:0] hit_pipe_reg [DEPTH];
    logic [DEPTH-1:0]       valid_pipe_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) hit_pipe_reg[i] <= '0;
            valid_pipe_reg <= '0;
        end else begin
            hit_pipe_reg[0]   <= hit_a;
            valid_pipe_reg[0] <= bus.valid;
            for (int i = 1; i < DEPTH; i++) begin
                hit_pipe_reg[i]   <= hit_pipe_reg[i-1];
                valid_pipe_reg[i] <= valid_pipe_reg[i-1];
            end
        end
    end

    logic [NUM_SPRITES-1:0] hit_d;
    logic                   valid_d;
    logic [NUM_SPRITES-1:0] opaque;
    logic [NUM_PAIRS-1:0]   pair_now;

    assign hit_d   = hit_pipe_reg[DEPTH-1];
    assign valid_d = valid_pipe_reg[DEPTH-1];

    generate
        for (gi = 0; gi < NUM_SPRITES; gi++) begin : g_opaque
            assign opaque[gi] = hit_d[gi] && (bus.spr_rgb[6*gi +: 6] != KEY_RGB);
        end
        // Pair (i,j), i<j, maps to a row-major index over the upper triangle.
        for (gi = 0; gi < NUM_SPRITES; gi++) begin : g_pi
            for (gj = gi + 1; gj < NUM_SPRITES; gj++) begin : g_pj
                localparam int IDX = gi * (2 * NUM_SPRITES - gi - 1) / 2 + (gj - gi - 1);
                assign pair_now[IDX] = valid_d && opaque[gi] && opaque[gj];
            end
        end
    endgenerate

    logic [5:0] rgb_next;

    always_comb begin
        rgb_next = bus.bg_rgb;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (opaque[i]) rgb_next = bus.spr_rgb[6*i +: 6];
        end
        if (!valid_d) rgb_next = '0;
    end

    logic [5:0]           rgb_reg;
    logic                 valid_out_reg;
    logic [NUM_PAIRS-1:0] acc_reg;
    logic [NUM_PAIRS-1:0] coll_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rgb_reg       <= '0;
            valid_out_reg <= 1'b0;
            acc_reg       <= '0;
            coll_reg      <= '0;
        end else begin
            rgb_reg       <= rgb_next;
            valid_out_reg <= valid_d;
            if (bus.frame_tick) begin
                coll_reg <= acc_reg | pair_now;
                acc_reg  <= '0;
            end else begin
                acc_reg  <= acc_reg | pair_now;
            end
        end
    end

    assign bus.rgb_out    = rgb_reg;
    assign bus.valid_out  = valid_out_reg;
    assign bus.coll_pairs = coll_reg;
    assign bus.any_coll   = |coll_reg;
endmodule

// File: tb/tb_sprite_compositor.sv
// Directed bench for sprite_compositor with hand-computed expectations
// (NUM_SPRITES=2, ROM_LATENCY=1, SCALE_SHIFT=1, key 6'h33).
module tb_sprite_compositor;
    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    sprite_compositor_if #(.NUM_SPRITES(2), .ADDR_W(14)) bus ();

    sprite_compositor #(
        .NUM_SPRITES(2), .ROM_LATENCY(1), .ADDR_W(14),
        .SCALE_SHIFT(1), .KEY_RGB(6'b110011)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        bus.frame_tick = 1'b1;
        step();
        bus.frame_tick = 1'b0;
    endtask

    task automatic set_ch(input int ch, input logic en, input logic [9:0] x, input logic [9:0] y,
                          input logic [6:0] w, input logic [6:0] h, input logic flip,
                          input logic [7:0] stride, input logic [10:0] arow, input logic [10:0] acol);
        bus.attr_en[ch]              = en;
        bus.attr_x[10*ch +: 10]      = x;
        bus.attr_y[10*ch +: 10]      = y;
        bus.attr_w[7*ch +: 7]        = w;
        bus.attr_h[7*ch +: 7]        = h;
        bus.attr_flip[ch]            = flip;
        bus.attr_stride[8*ch +: 8]   = stride;
        bus.attr_anim_row[11*ch +: 11] = arow;
        bus.attr_anim_col[11*ch +: 11] = acol;
    endtask

    task automatic addr_at(input string tag, input logic [9:0] c, input logic [9:0] r,
                           input logic [13:0] exp);
        bus.col = c;
        bus.row = r;
        step();
        check(tag, 32'(bus.spr_addr[13:0]), 32'(exp));
    endtask

    // One valid pixel, then confirm rgb_out shows it exactly 3 cycles later and only then.
    task automatic rgb_lat(input string tag, input logic [9:0] c, input logic [9:0] r,
                           input logic [11:0] rgb, input logic [5:0] bg, input logic [5:0] exp);
        bus.spr_rgb = rgb;
        bus.bg_rgb  = bg;
        bus.col     = c;
        bus.row     = r;
        bus.valid   = 1'b1;
        step();
        bus.valid   = 1'b0;
        step();
        check({tag, "_early"}, 32'(bus.rgb_out), 32'h0);
        step();
        check(tag, 32'(bus.rgb_out), 32'(exp));
        check({tag, "_vout"}, 32'(bus.valid_out), 32'h1);
        step();
        check({tag, "_late"}, 32'(bus.rgb_out), 32'h0);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.col = '0; bus.row = '0; bus.valid = 1'b0; bus.frame_tick = 1'b0;
        bus.attr_en = '0; bus.attr_x = '0; bus.attr_y = '0; bus.attr_w = '0; bus.attr_h = '0;
        bus.attr_flip = '0; bus.attr_stride = '0; bus.attr_anim_row = '0; bus.attr_anim_col = '0;
        bus.spr_rgb = '0; bus.bg_rgb = '0;
        step();
        step();
        check("rst_addr", 32'(bus.spr_addr), 32'h0);
        check("rst_rgb", 32'(bus.rgb_out), 32'h0);
        check("rst_vout", 32'(bus.valid_out), 32'h0);
        check("rst_coll", 32'(bus.coll_pairs), 32'h0);
        check("rst_any", 32'(bus.any_coll), 32'h0);
        rst_n = 1'b1;

        // Basic addressing, scale 2, including the right/bottom edges.
        set_ch(0, 1'b1, 10'd50, 10'd290, 7'd23, 7'd30, 1'b0, 8'd23, 11'd0, 11'd0);
        tick();
        addr_at("t1_origin", 10'd50, 10'd290, 14'd0);
        addr_at("t1_inner", 10'd52, 10'd292, 14'd24);
        addr_at("t1_right_miss", 10'd96, 10'd290, 14'd0);
        addr_at("t1_right_last", 10'd95, 10'd290, 14'd22);
        addr_at("t1_bottom_last", 10'd50, 10'd349, 14'd667);
        addr_at("t1_bottom_miss", 10'd50, 10'd350, 14'd0);
        addr_at("t1_left_miss", 10'd49, 10'd290, 14'd0);

        // Flip and animation offsets.
        set_ch(0, 1'b1, 10'd50, 10'd290, 7'd23, 7'd30, 1'b1, 8'd23, 11'd0, 11'd0);
        tick();
        addr_at("t2_flip", 10'd50, 10'd290, 14'd22);
        set_ch(0, 1'b1, 10'd50, 10'd290, 7'd23, 7'd30, 1'b1, 8'd92, 11'd30, 11'd23);
        tick();
        addr_at("t2_anim", 10'd50, 10'd290, 14'd2805);

        // Priority, colour key and valid gating on an overlapping pixel.
        set_ch(0, 1'b1, 10'd50, 10'd290, 7'd23, 7'd30, 1'b0, 8'd23, 11'd0, 11'd0);
        set_ch(1, 1'b1, 10'd60, 10'd300, 7'd10, 7'd10, 1'b0, 8'd10, 11'd0, 11'd0);
        tick();
        rgb_lat("t3_key0", 10'd60, 10'd300, {6'h0F, 6'h33}, 6'h01, 6'h0F);
        rgb_lat("t3_bothkey", 10'd60, 10'd300, {6'h33, 6'h33}, 6'h01, 6'h01);
        rgb_lat("t3_prio", 10'd60, 10'd300, {6'h0F, 6'h2A}, 6'h01, 6'h2A);
        bus.valid = 1'b0;
        step(); step(); step();
        check("t3_novalid_rgb", 32'(bus.rgb_out), 32'h0);
        check("t3_novalid_vout", 32'(bus.valid_out), 32'h0);

        // Collision snapshot appears only after the frame boundary.
        check("t4_pre_tick", 32'(bus.coll_pairs), 32'h0);
        tick();
        check("t4_coll", 32'(bus.coll_pairs), 32'h1);
        check("t4_any", 32'(bus.any_coll), 32'h1);
        rgb_lat("t4_keyed_overlap", 10'd60, 10'd300, {6'h0F, 6'h33}, 6'h01, 6'h0F);
        rgb_lat("t4_solo", 10'd50, 10'd290, {6'h0F, 6'h2A}, 6'h01, 6'h2A);
        check("t4_hold", 32'(bus.coll_pairs), 32'h1);
        tick();
        check("t4_clear", 32'(bus.coll_pairs), 32'h0);
        check("t4_any_clear", 32'(bus.any_coll), 32'h0);

        // Mid-frame attribute change waits for the tick.
        bus.attr_x[9:0] = 10'd200;
        addr_at("t5_old_hit", 10'd52, 10'd292, 14'd24);
        addr_at("t5_new_miss", 10'd202, 10'd292, 14'd0);
        tick();
        addr_at("t5_old_miss", 10'd52, 10'd292, 14'd0);
        addr_at("t5_new_hit", 10'd202, 10'd292, 14'd24);

        // Reset in the middle of live, colliding pixels.
        bus.attr_x[9:0] = 10'd50;
        tick();
        bus.spr_rgb = {6'h0F, 6'h2A};
        bus.bg_rgb  = 6'h01;
        bus.col     = 10'd60;
        bus.row     = 10'd300;
        bus.valid   = 1'b1;
        step(); step(); step();
        check("t6_live", 32'(bus.rgb_out), 32'h2A);
        tick();
        check("t6_coll_visible_tick", 32'(bus.coll_pairs), 32'h1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("t6_rst_rgb", 32'(bus.rgb_out), 32'h0);
        check("t6_rst_coll", 32'(bus.coll_pairs), 32'h0);
        check("t6_rst_any", 32'(bus.any_coll), 32'h0);
        check("t6_rst_addr", 32'(bus.spr_addr), 32'h0);
        step(); step(); step();
        check("t6_disabled_bg", 32'(bus.rgb_out), 32'h01);
        check("t6_disabled_addr", 32'(bus.spr_addr[13:0]), 32'h0);
        tick();
        check("t6_tick_cycle_addr", 32'(bus.spr_addr[13:0]), 32'h0);
        step();
        check("t6_reenabled_addr", 32'(bus.spr_addr[13:0]), 32'd120);
        step(); step();
        check("t6_reenabled_rgb", 32'(bus.rgb_out), 32'h2A);
        bus.valid = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sprite_compositor.md
Name: sprite_compositor

Overview:
Parametrised N-channel sprite engine that replaces the hand-wired per-character hit/address/priority logic at the top level. It takes the VGA scan position and, for each channel, computes the hit and the ROM address, with integer scaling, horizontal flip and animation-frame offset. It aligns the per-channel ROM returns with the valid and hit flags across a configurable ROM latency, and priority-composites over a background pixel. It also reports pixel-accurate pairwise sprite collisions once per frame.

Parameters:
NUM_SPRITES, 2, number of sprite channels; channel 0 has the highest priority.
ROM_LATENCY, 1, cycles from a registered spr_addr to the matching spr_rgb (at least 1).
ADDR_W, 14, width of each channel's ROM address.
SCALE_SHIFT, 1, on-screen scale factor is 2^SCALE_SHIFT in both axes.
KEY_RGB, 6'b110011, transparent colour key.

Ports:
clk  in  1  pixel clock
rst_n  in  1  synchronous active-low reset
col  in  10  scan column; same timing as the vga next_col
row  in  10  scan row
valid  in  1  visible-area flag for col/row
frame_tick  in  1  one-cycle pulse per frame, at vblank
attr_en  in  NUM_SPRITES  live channel enable
attr_x  in  10*NUM_SPRITES  live top-left x, packed, channel i at [10i+:10]
attr_y  in  10*NUM_SPRITES  live top-left y
attr_w  in  7*NUM_SPRITES  unscaled width in source pixels (1..127)
attr_h  in  7*NUM_SPRITES  unscaled height in source pixels (1..127)
attr_flip  in  NUM_SPRITES  1 = mirror horizontally
attr_stride  in  8*NUM_SPRITES  sheet row width in source pixels
attr_anim_row  in  11*NUM_SPRITES  animation frame row offset
attr_anim_col  in  11*NUM_SPRITES  animation frame column offset
spr_addr  out  ADDR_W*NUM_SPRITES  per-channel ROM address, registered
spr_rgb  in  6*NUM_SPRITES  per-channel ROM data, ROM_LATENCY after spr_addr
bg_rgb  in  6  background pixel, presented in the same cycle as the matching spr_rgb
rgb_out  out  6  composited pixel, registered
valid_out  out  1  valid delayed to align with rgb_out
coll_pairs  out  NUM_SPRITES*(NUM_SPRITES-1)/2  per-pair collision flags for the last frame
any_coll  out  1  OR of coll_pairs

Behaviour:
- Reset (rst_n=0 at a clk edge): all shadow attributes are 0, so every channel is disabled. spr_addr=0, rgb_out=0, valid_out=0, coll_pairs=0, any_coll=0. All delay lines and the collision accumulator are cleared. Reset takes priority over frame_tick.
- Shadow attributes: all attr_* inputs are copied into the active set only on the frame_tick cycle. Mid-frame attribute changes have no effect until the next tick, so there is no tearing.
- Stage A (cycle t, combinational from col/row and active attributes), per channel i:
  - Scaled extents: sw = w<<SCALE_SHIFT, sh = h<<SCALE_SHIFT.
  - hit_i = en_i && col>=x_i && col<x_i+sw && row>=y_i && row<y_i+sh.
  - All comparisons are done at 11 bits, so x+sw past 1023 does not wrap.
  - Source offsets: cx = (col-x_i)>>SCALE_SHIFT, ry = (row-y_i)>>SCALE_SHIFT.
  - When flip_i=1, cx is replaced by w_i-1-cx.
  - addr_i = (ry+anim_row_i)*stride_i + cx + anim_col_i, truncated to ADDR_W.
  - addr_i = 0 when hit_i=0.
- spr_addr is registered at t+1.
- hit vector and valid pass through a delay line of 1+ROM_LATENCY stages, so they align with spr_rgb and bg_rgb at t+1+ROM_LATENCY.
- Compose (registered, output at t+2+ROM_LATENCY):
  - opaque_i = hit_d_i && spr_rgb_i != KEY_RGB.
  - rgb_out = spr_rgb of the lowest-index opaque channel; otherwise bg_rgb.
  - rgb_out = 0 when valid_d=0.
  - Total col/row-to-rgb_out latency is ROM_LATENCY+2.
- Collision, for each pair (i<j): if valid_d && opaque_i && opaque_j, set acc bit (i,j).
  - Pair bit index follows row-major order over the i<j pairs: (0,1),(0,2),...,(1,2),...
  - On frame_tick: coll_pairs <= acc | current-cycle hits; acc <= 0.
  - coll_pairs holds its value for a full frame.
  - Key-coloured pixels never count as a collision.
- Boundaries:
  - A zero-enable channel never hits.
  - Overlapping channels: the lower index wins for colour; both still register a collision.
  - frame_tick during a visible pixel: shadow update and collision snapshot happen in the same cycle; pixels already in the pipeline finish with their old addresses.

Test Plan:
1. Reset, then one frame_tick with ch0 en=1, x=50, y=290, w=23, h=30, stride=23, no flip, SCALE_SHIFT=1; drive col=50,row=290 → spr_addr0=0 one cycle later. col=52,row=292 → spr_addr0=24 (1*23+1). col=96 → hit0=0, spr_addr0=0.
2. Same channel with flip=1 at col=50, row=290 → spr_addr0=22. With anim_col=23, anim_row=30 and stride=92 at the same position → (0+30)*92 + 22+23 = 2805.
3. Priority and key: ch0 and ch1 cover the same pixel, ch0 data=KEY_RGB, ch1 data=6'h0F, bg=6'h01 → rgb_out=6'h0F exactly ROM_LATENCY+2 cycles after col/row. With both channels keyed → rgb_out=6'h01. With valid=0 → rgb_out=0.
4. Collision: overlap ch0/ch1 opaque pixels in frame N → coll_pairs=1 and any_coll=1 after the next frame_tick. No overlap in frame N+1 → coll_pairs=0 after the following tick.
5. Shadow update: change attr_x0 from 50 to 200 mid-frame → hits remain at x=50 until frame_tick, then move to x=200.
6. Reset mid-frame while rgb_out is non-zero → rgb_out=0 next cycle, coll_pairs=0, and all channels stay disabled until the next frame_tick.
